// File: rtl/oam_dma_ctrl.sv
// Sprite DMA sequencer: passes CPU accesses through to the system bus when idle and,
// on a write to the DMA register, halts the CPU and copies one page into OAM.
module oam_dma_ctrl #(
    parameter logic [15:0] DMA_REG_ADDR  = 16'h4014,
    parameter logic [15:0] OAM_DATA_ADDR = 16'h2004
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] cpu_mem_addr,
    input  logic [7:0]  cpu_mem_data_out,
    input  logic        cpu_mem_write_en,
    input  logic        cpu_mem_read_en,
    input  logic [7:0]  bus_data_in,
    output logic [15:0] bus_addr,
    output logic [7:0]  bus_data_out,
    output logic        bus_write_en,
    output logic        bus_read_en,
    output logic        cpu_halt,
    output logic        dma_active
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SYNC  = 2'd1,
        READ  = 2'd2,
        WRITE = 2'd3
    } state_t;

    state_t     state_reg;
    logic [7:0] page_reg;
    logic [7:0] cnt_reg;
    logic [7:0] latch_reg;
    logic       odd_reg;

    logic       dma_trigger;

    assign dma_trigger = cpu_mem_write_en && (cpu_mem_addr == DMA_REG_ADDR);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg <= IDLE;
            page_reg  <= 8'h00;
            cnt_reg   <= 8'h00;
            latch_reg <= 8'h00;
            odd_reg   <= 1'b0;
        end else begin
            odd_reg <= ~odd_reg;
            case (state_reg)
                IDLE: begin
                    if (dma_trigger) begin
                        page_reg  <= cpu_mem_data_out;
                        cnt_reg   <= 8'h00;
                        state_reg <= SYNC;
                    end
                end
                // Leave SYNC only from an odd cycle so the first READ lands on an even one.
                SYNC: begin
                    if (odd_reg) begin
                        state_reg <= READ;
                    end
                end
                READ: begin
                    state_reg <= WRITE;
                end
                WRITE: begin
                    latch_reg <= bus_data_in;
                    if (cnt_reg == 8'hFF) begin
                        state_reg <= IDLE;
                    end else begin
                        cnt_reg   <= cnt_reg + 8'd1;
                        state_reg <= READ;
                    end
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    always_comb begin
        bus_addr     = 16'h0000;
        bus_data_out = 8'h00;
        bus_write_en = 1'b0;
        bus_read_en  = 1'b0;
        case (state_reg)
            IDLE: begin
                bus_addr     = cpu_mem_addr;
                bus_data_out = cpu_mem_data_out;
                bus_write_en = cpu_mem_write_en && !dma_trigger;
                bus_read_en  = cpu_mem_read_en;
            end
            SYNC: begin
                bus_addr = 16'h0000;
            end
            // Write strobe is low here; the previous byte sits on the data lines for debug.
            READ: begin
                bus_addr     = {page_reg, cnt_reg};
                bus_read_en  = 1'b1;
                bus_data_out = latch_reg;
            end
            WRITE: begin
                bus_addr     = OAM_DATA_ADDR;
                bus_data_out = bus_data_in;
                bus_write_en = 1'b1;
            end
            default: begin
                bus_addr = 16'h0000;
            end
        endcase
    end

    assign cpu_halt   = (state_reg != IDLE);
    assign dma_active = cpu_halt;

endmodule

// File: tb/tb_oam_dma_ctrl.sv
// Directed bench for oam_dma_ctrl: pass-through, parity-aligned DMA, retrigger,
// mid-transfer reset and page-FF boundary, against a bench-side memory and OAM log.
module tb_oam_dma_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] cpu_mem_addr;
    logic [7:0]  cpu_mem_data_out;
    logic        cpu_mem_write_en;
    logic        cpu_mem_read_en;
    logic [7:0]  bus_data_in = 8'h00;
    logic [15:0] bus_addr;
    logic [7:0]  bus_data_out;
    logic        bus_write_en;
    logic        bus_read_en;
    logic        cpu_halt;
    logic        dma_active;

    int checks   = 0;
    int failures = 0;

    logic [7:0]  mem [0:65535];
    logic [7:0]  oam_q [$];
    int          rd_total     = 0;
    int          rd_bad       = 0;
    logic [15:0] last_rd_addr = 16'h0000;
    logic [7:0]  exp_page     = 8'h00;
    logic        tb_odd;

    always #5 clk = ~clk;

    oam_dma_ctrl dut (
        .clk              (clk),
        .rst              (rst),
        .cpu_mem_addr     (cpu_mem_addr),
        .cpu_mem_data_out (cpu_mem_data_out),
        .cpu_mem_write_en (cpu_mem_write_en),
        .cpu_mem_read_en  (cpu_mem_read_en),
        .bus_data_in      (bus_data_in),
        .bus_addr         (bus_addr),
        .bus_data_out     (bus_data_out),
        .bus_write_en     (bus_write_en),
        .bus_read_en      (bus_read_en),
        .cpu_halt         (cpu_halt),
        .dma_active       (dma_active)
    );

    // Cycle parity as defined for the block: 0 in the first cycle after reset release.
    always @(posedge clk or negedge rst) begin
        if (!rst) tb_odd <= 1'b0;
        else      tb_odd <= ~tb_odd;
    end

    // Memory with one-cycle read latency; $2004 writes go to the OAM log.
    always @(posedge clk) begin
        if (bus_read_en) bus_data_in <= mem[bus_addr];
        if (bus_write_en) begin
            if (bus_addr == 16'h2004) oam_q.push_back(bus_data_out);
            else                      mem[bus_addr] <= bus_data_out;
        end
        if (bus_read_en && cpu_halt) begin
            rd_total     <= rd_total + 1;
            last_rd_addr <= bus_addr;
            if (bus_addr[15:8] != exp_page) rd_bad <= rd_bad + 1;
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cpu_idle();
        cpu_mem_addr     = 16'h0000;
        cpu_mem_data_out = 8'h00;
        cpu_mem_write_en = 1'b0;
        cpu_mem_read_en  = 1'b0;
    endtask

    task automatic preload(input logic [7:0] pg, input logic [7:0] x);
        for (int i = 0; i < 256; i++) begin
            @(negedge clk);
            cpu_mem_addr     = {pg, 8'(i)};
            cpu_mem_data_out = 8'(i) ^ x;
            cpu_mem_write_en = 1'b1;
            cpu_mem_read_en  = 1'b0;
        end
        @(negedge clk);
        cpu_idle();
    endtask

    // Trigger a DMA so that the cycle after the trigger has parity t1_odd, then follow it.
    task automatic run_dma(input logic [7:0] pg, input bit t1_odd, input int abort_at,
                           input bit retrig, output int halt_len);
        int  n;
        int  base;
        bit  first;
        base     = oam_q.size();
        exp_page = pg;
        @(negedge clk);
        while (tb_odd != (t1_odd ? 1'b0 : 1'b1)) @(negedge clk);
        cpu_mem_addr     = 16'h4014;
        cpu_mem_data_out = pg;
        cpu_mem_write_en = 1'b1;
        cpu_mem_read_en  = 1'b0;
        #1;
        check("trigger_write_blocked", 32'(bus_write_en), 32'd0);
        check("trigger_halt_low", 32'(cpu_halt), 32'd0);
        @(negedge clk);
        cpu_idle();
        check("halt_rise", 32'(cpu_halt), 32'd1);
        check("dma_active_rise", 32'(dma_active), 32'd1);
        n     = 0;
        first = 1'b1;
        while (cpu_halt && n < 1000) begin
            if (bus_read_en && first) begin
                first = 1'b0;
                check("first_read_even", 32'(tb_odd), 32'd0);
                check("first_read_dut_odd", 32'(dut.odd_reg), 32'd0);
                check("first_read_addr", 32'(bus_addr), 32'({pg, 8'h00}));
            end
            if (abort_at > 0 && oam_q.size() - base == abort_at) begin
                rst = 1'b0;
                #1;
                check("abort_halt_low", 32'(cpu_halt), 32'd0);
                check("abort_active_low", 32'(dma_active), 32'd0);
                check("abort_cnt_cleared", 32'(dut.cnt_reg), 32'd0);
                repeat (3) @(negedge clk);
                check("abort_no_more_writes", 32'(oam_q.size() - base), 32'(abort_at));
                cpu_idle();
                rst = 1'b1;
                @(negedge clk);
                check("abort_stays_idle", 32'(cpu_halt), 32'd0);
                break;
            end
            if (retrig && n == 50) begin
                cpu_mem_addr     = 16'h4014;
                cpu_mem_data_out = 8'h07;
                cpu_mem_write_en = 1'b1;
            end else if (n == 51) begin
                cpu_idle();
            end else if (n == 60) begin
                cpu_mem_addr    = 16'h0555;
                cpu_mem_read_en = 1'b1;
            end
            n++;
            @(negedge clk);
        end
        halt_len = n;
        if (abort_at == 0) begin
            check("resume_read_en", 32'(bus_read_en), 32'd1);
            check("resume_addr", 32'(bus_addr), 32'h0555);
            cpu_idle();
        end
    endtask

    task automatic check_copy(input string tag, input int base, input logic [7:0] x);
        int mism;
        mism = 0;
        check({tag, "_count"}, 32'(oam_q.size() - base), 32'd256);
        if (oam_q.size() - base >= 256) begin
            for (int i = 0; i < 256; i++)
                if (oam_q[base + i] !== (8'(i) ^ x)) mism++;
        end
        check({tag, "_data_mismatches"}, 32'(mism), 32'd0);
    endtask

    initial begin
        int hl;
        int base;
        int rd0;
        int bad0;
        int late;

        rst = 1'b0;
        cpu_idle();
        repeat (3) @(negedge clk);
        check("rst_halt", 32'(cpu_halt), 32'd0);
        check("rst_active", 32'(dma_active), 32'd0);
        check("rst_page", 32'(dut.page_reg), 32'd0);
        check("rst_latch", 32'(dut.latch_reg), 32'd0);
        cpu_mem_addr    = 16'h1234;
        cpu_mem_read_en = 1'b1;
        #1;
        check("rst_passthru_addr", 32'(bus_addr), 32'h1234);
        check("rst_passthru_rd", 32'(bus_read_en), 32'd1);
        cpu_idle();
        rst = 1'b1;
        #1;
        check("odd_first_cycle", 32'(dut.odd_reg), 32'd0);
        @(posedge clk);
        #1;
        check("odd_second_cycle", 32'(dut.odd_reg), 32'd1);

        // Pass-through write, read-back and simultaneous strobes.
        @(negedge clk);
        cpu_mem_addr     = 16'h0200;
        cpu_mem_data_out = 8'h5A;
        cpu_mem_write_en = 1'b1;
        #1;
        check("pt_wr_addr", 32'(bus_addr), 32'h0200);
        check("pt_wr_data", 32'(bus_data_out), 32'h5A);
        check("pt_wr_en", 32'(bus_write_en), 32'd1);
        check("pt_wr_halt", 32'(cpu_halt), 32'd0);
        @(negedge clk);
        cpu_mem_write_en = 1'b0;
        cpu_mem_read_en  = 1'b1;
        #1;
        check("pt_rd_en", 32'(bus_read_en), 32'd1);
        check("pt_rd_wr_low", 32'(bus_write_en), 32'd0);
        @(negedge clk);
        check("pt_rd_data", 32'(bus_data_in), 32'h5A);
        cpu_mem_addr     = 16'h0201;
        cpu_mem_data_out = 8'h3C;
        cpu_mem_write_en = 1'b1;
        cpu_mem_read_en  = 1'b1;
        #1;
        check("pt_both_wr", 32'(bus_write_en), 32'd1);
        check("pt_both_rd", 32'(bus_read_en), 32'd1);
        @(negedge clk);
        cpu_mem_addr     = 16'h4014;
        cpu_mem_write_en = 1'b0;
        cpu_mem_read_en  = 1'b1;
        #1;
        check("dmareg_read_passes", 32'(bus_read_en), 32'd1);
        @(negedge clk);
        cpu_idle();
        check("dmareg_read_no_dma", 32'(cpu_halt), 32'd0);

        // Full DMA, T+1 odd.
        preload(8'h03, 8'hA5);
        base = oam_q.size();
        rd0  = rd_total;
        run_dma(8'h03, 1'b1, 0, 1'b0, hl);
        check("halt_len_odd", 32'(hl), 32'd513);
        check_copy("copy_odd", base, 8'hA5);
        check("reads_odd", 32'(rd_total - rd0), 32'd256);
        check("latch_last", 32'(dut.latch_reg), 32'h5A);

        // Full DMA, T+1 even, with a retrigger attempt mid-transfer.
        base = oam_q.size();
        run_dma(8'h03, 1'b0, 0, 1'b1, hl);
        check("halt_len_even", 32'(hl), 32'd514);
        check("retrig_page_kept", 32'(dut.page_reg), 32'h03);
        late = 0;
        repeat (20) begin
            @(negedge clk);
            if (cpu_halt) late++;
        end
        check("retrig_no_second_dma", 32'(late), 32'd0);
        check_copy("copy_even", base, 8'hA5);

        // Reset after 100 bytes, then a clean full copy.
        base = oam_q.size();
        run_dma(8'h03, 1'b1, 100, 1'b0, hl);
        check("abort_bytes", 32'(oam_q.size() - base), 32'd100);
        base = oam_q.size();
        run_dma(8'h03, 1'b1, 0, 1'b0, hl);
        check("post_abort_halt_len", 32'(hl), 32'd513);
        check_copy("copy_post_abort", base, 8'hA5);

        // Page FF: addresses stay within $FF00..$FFFF.
        preload(8'hFF, 8'h5A);
        base = oam_q.size();
        rd0  = rd_total;
        bad0 = rd_bad;
        run_dma(8'hFF, 1'b0, 0, 1'b0, hl);
        check("pageff_halt_len", 32'(hl), 32'd514);
        check("pageff_reads", 32'(rd_total - rd0), 32'd256);
        check("pageff_no_wrap", 32'(rd_bad - bad0), 32'd0);
        check("pageff_last_addr", 32'(last_rd_addr), 32'hFFFF);
        check_copy("copy_pageff", base, 8'h5A);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/oam_dma_ctrl.md
# oam_dma_ctrl

Bus-sequencing controller between `cpu_6502`'s memory bus and the system memory bus. When idle, it passes CPU accesses straight through. A CPU write to the DMA register ($4014) starts a 256-byte sprite DMA. The block then halts the CPU, takes ownership of the bus, and copies page `{D,8'h00}..{D,8'hFF}` to the PPU OAM data port ($2004). Each byte takes one read cycle followed by one write cycle, aligned to an even CPU cycle.

## Interface

Parameters
- `DMA_REG_ADDR`, 16'h4014, CPU write address that triggers DMA.
- `OAM_DATA_ADDR`, 16'h2004, destination address for every DMA write.

Ports
- `clk`  in  1  system clock; all state changes on the rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `cpu_mem_addr`  in  16  CPU bus address.
- `cpu_mem_data_out`  in  8  CPU write data.
- `cpu_mem_write_en`  in  1  CPU write strobe.
- `cpu_mem_read_en`  in  1  CPU read strobe.
- `bus_data_in`  in  8  read data from memory; valid the cycle after `bus_read_en`.
- `bus_addr`  out  16  system bus address.
- `bus_data_out`  out  8  system bus write data.
- `bus_write_en`  out  1  system bus write strobe.
- `bus_read_en`  out  1  system bus read strobe.
- `cpu_halt`  out  1  high while DMA owns the bus; the CPU must hold state.
- `dma_active`  out  1  identical to `cpu_halt`; used for PPU/debug.

## Operation

- States: IDLE, SYNC, READ, WRITE.
- Registers:
  - `page` (8b), source page.
  - `cnt` (8b), byte index.
  - `latch` (8b), captured read data.
  - `odd` (1b), free-running cycle parity; toggles every clock and is 0 in the first cycle after reset release.
- IDLE
  - `bus_*` = `cpu_*` combinationally.
  - Exception: when `cpu_mem_write_en && cpu_mem_addr==DMA_REG_ADDR`, `bus_write_en` is forced to 0; the write is consumed, not forwarded.
  - On that trigger: `page<=cpu_mem_data_out`, `cnt<=0`, next state SYNC.
  - A read of `DMA_REG_ADDR` passes through and has no effect.
- SYNC
  - Bus idle: `bus_read_en=0`, `bus_write_en=0`, `bus_addr=0`, `bus_data_out=0`.
  - Next state is READ when `odd==1`; otherwise stay in SYNC. SYNC therefore lasts 1 or 2 cycles, and the first READ always falls on an even cycle.
- READ
  - Drives `bus_addr={page,cnt}` and `bus_read_en=1`.
  - Next state WRITE.
- WRITE
  - Drives `bus_addr=OAM_DATA_ADDR`, `bus_data_out=bus_data_in`, `bus_write_en=1`.
  - Also registers `bus_data_in` into `latch` for debug visibility.
  - If `cnt==8'hFF`: next state IDLE.
  - Else: `cnt<=cnt+1`, next state READ. `cnt` never wraps past FF during a transfer.
- `cpu_halt = (state != IDLE)`, decoded combinationally from the state register.
- All `cpu_*` inputs are ignored outside IDLE, including further writes to `DMA_REG_ADDR`.

## Timing

- Reset (rst=0, async):
  - State IDLE; `page`, `cnt`, `latch` = 0; `odd` = 0.
  - `cpu_halt=0`, `dma_active=0`. `bus_*` follows `cpu_*` (pass-through).
- Reset asserted mid-DMA: transfer aborts immediately. There is no resume; remaining OAM bytes are left unwritten.
- Trigger in cycle T (IDLE): `cpu_halt` rises in T+1.
- Halt length is exactly 513 cycles when T+1 is an odd cycle and 514 when T+1 is even:
  - 1 or 2 SYNC cycles,
  - then 256 × (READ, WRITE).
- `cpu_halt` falls in the cycle after the final WRITE. The CPU's pass-through access resumes in that same cycle.
- Read-to-write latency: 1 cycle. Memory must return data the cycle after `bus_read_en`.
- Simultaneous CPU read/write strobes in IDLE pass through unchanged; arbitration belongs to the CPU.

## Test plan

1. **Pass-through.** In IDLE, CPU writes 8'h5A to 16'h0200, then reads 16'h0200. Required: `bus_*` equals `cpu_*` in the same cycle, `cpu_halt=0`, and read data matches.
2. **Full DMA, even start.**
   - Preload RAM $0300+i = i^8'hA5.
   - Trigger a write of 8'h03 to $4014 so that T+1 is an odd cycle.
   - Required: `cpu_halt` is high for 513 cycles; 256 writes to $2004 with data i^8'hA5 in order i=0..255; `bus_write_en` low on the trigger cycle.
3. **Parity alignment.** Same as test 2 but with T+1 an even cycle. Required: halt of 514 cycles, and the first READ occurs on a cycle where `odd==0`.
4. **Retrigger ignored.** During DMA, the CPU model drives a write of 8'h07 to $4014. Required: `page` stays 8'h03, the transfer completes normally, and no second DMA follows.
5. **Reset mid-DMA.** Assert `rst=0` after 100 bytes. Required: `cpu_halt=0` asynchronously, no further $2004 writes, state IDLE. After release, a new trigger performs a full 256-byte copy.
6. **Page boundary.** Trigger with 8'hFF. Required: reads cover $FF00..$FFFF and the last READ address is 16'hFFFF; no wrap to $0000.
